// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller.
// Holds the run FSM state encoding.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } run_state_t;

endpackage

// File: rtl/mem_port_mux.sv
// Data memory port select between host and core.
// Host writes only reach memory in an accepted host cycle.
module mem_port_mux #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          sel_core,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    always_comb begin
        mem_we    = host_en & host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (sel_core) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: host preload/readback, core release,
// cycle counting and timeout abort.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TW      = 16,
    parameter int MAX_CYC = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          core_reset,
    input  logic          core_done,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          run_done,
    output logic          timeout,
    output logic [TW-1:0] cycles
);

    localparam logic [TW-1:0] LIM = TW'(MAX_CYC - 1);

    run_state_t state_q;
    run_state_t state_d;
    logic       accept;
    logic       at_lim;
    logic       in_run;

    assign in_run     = (state_q == RUN);
    assign at_lim     = (cycles == LIM);
    assign accept     = (state_q == IDLE) & host_req
                      & ~host_ack & ~start;
    assign core_reset = ~in_run;
    assign busy       = (state_q != IDLE);
    assign core_rdata = mem_rdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (core_done || at_lim) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            run_done   <= 1'b0;
            timeout    <= 1'b0;
            cycles     <= '0;
        end else begin
            state_q  <= state_d;
            host_ack <= accept;
            if (accept) begin
                host_rdata <= host_we ? '0 : mem_rdata;
            end
            if (state_q == IDLE && start) begin
                run_done <= 1'b0;
                timeout  <= 1'b0;
                cycles   <= '0;
            end else if (in_run) begin
                // done beats the limit in the same cycle
                if (core_done) begin
                    run_done <= 1'b1;
                    timeout  <= 1'b0;
                end else begin
                    cycles <= cycles + 1'b1;
                    if (at_lim) begin
                        run_done <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
            end
        end
    end

    mem_port_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .sel_core  (in_run),
        .host_en   (accept),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule
